// File: rtl/matcop_issue_ctrl_if.sv
// rtl/matcop_issue_ctrl_if.sv - issue, coprocessor and writeback signal bundle for matcop_issue_ctrl
interface matcop_issue_ctrl_if #(
    parameter int OPC_W = 6,
    parameter int GPR_W = 32,
    parameter int RA_W  = 5
);
    logic             issue_valid;
    logic             issue_ready;
    logic [OPC_W-1:0] issue_op;
    logic [GPR_W-1:0] issue_rs;
    logic [GPR_W-1:0] issue_rt;
    logic [RA_W-1:0]  issue_rd;
    logic             flush;
    logic             stall;
    logic [OPC_W-1:0] cop_op;
    logic [GPR_W-1:0] cop_rs;
    logic [GPR_W-1:0] cop_rt;
    logic [GPR_W-1:0] cop_rd_value;
    logic             cop_result_valid;
    logic             cop_error;
    logic             wb_valid;
    logic             wb_ready;
    logic [RA_W-1:0]  wb_rd;
    logic [GPR_W-1:0] wb_data;
    logic [1:0]       wb_exc;

    // Controller side
    modport slave (
        input  issue_valid, issue_op, issue_rs, issue_rt, issue_rd, flush,
        input  cop_rd_value, cop_result_valid, cop_error, wb_ready,
        output issue_ready, stall, cop_op, cop_rs, cop_rt,
        output wb_valid, wb_rd, wb_data, wb_exc
    );

    // Pipeline / coprocessor / writeback side
    modport master (
        output issue_valid, issue_op, issue_rs, issue_rt, issue_rd, flush,
        output cop_rd_value, cop_result_valid, cop_error, wb_ready,
        input  issue_ready, stall, cop_op, cop_rs, cop_rt,
        input  wb_valid, wb_rd, wb_data, wb_exc
    );
endinterface

// File: rtl/matcop_issue_ctrl.sv
// rtl/matcop_issue_ctrl.sv - issue/writeback controller for the multiply/divide-mod coprocessor
// Holds operands at the coprocessor while BUSY, captures result/error/timeout, hands off to writeback.
module matcop_issue_ctrl #(
    parameter int               OPC_W   = 6,
    parameter int               GPR_W   = 32,
    parameter int               RA_W    = 5,
    parameter logic [OPC_W-1:0] OP_NOP  = '0,
    parameter int               TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                rst,
    matcop_issue_ctrl_if.slave  bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] EXC_NONE    = 2'd0;
    localparam logic [1:0] EXC_DIV0    = 2'd1;
    localparam logic [1:0] EXC_TIMEOUT = 2'd2;

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [WD_W-1:0]  watchdog;
    logic [OPC_W-1:0] cop_op_q;
    logic [GPR_W-1:0] cop_rs_q;
    logic [GPR_W-1:0] cop_rt_q;
    logic             wb_valid_q;
    logic [RA_W-1:0]  wb_rd_q;
    logic [GPR_W-1:0] wb_data_q;
    logic [1:0]       wb_exc_q;

    logic cop_event;

    // Either flag ends the operation; an error alone is treated like a flagged error result.
    assign cop_event = bus.cop_result_valid | bus.cop_error;

    assign bus.issue_ready = (state == S_IDLE);
    assign bus.stall       = (bus.issue_valid & (state == S_IDLE))
                           | (state == S_BUSY)
                           | ((state == S_DONE) & ~bus.wb_ready);

    assign bus.cop_op   = cop_op_q;
    assign bus.cop_rs   = cop_rs_q;
    assign bus.cop_rt   = cop_rt_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_exc   = wb_exc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            watchdog   <= '0;
            cop_op_q   <= OP_NOP;
            cop_rs_q   <= '0;
            cop_rt_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_exc_q   <= EXC_NONE;
        end else if (bus.flush) begin
            // Abort: the coprocessor sees NOP and any pending result is dropped.
            state      <= S_IDLE;
            watchdog   <= '0;
            cop_op_q   <= OP_NOP;
            wb_valid_q <= 1'b0;
            wb_exc_q   <= EXC_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.issue_valid) begin
                        cop_op_q <= bus.issue_op;
                        cop_rs_q <= bus.issue_rs;
                        cop_rt_q <= bus.issue_rt;
                        wb_rd_q  <= bus.issue_rd;
                        watchdog <= '0;
                        state    <= S_BUSY;
                    end
                end

                S_BUSY: begin
                    watchdog <= watchdog + 1'b1;
                    // A result in the last watchdog cycle beats the timeout.
                    if (cop_event) begin
                        wb_data_q  <= bus.cop_error ? '0 : bus.cop_rd_value;
                        wb_exc_q   <= bus.cop_error ? EXC_DIV0 : EXC_NONE;
                        cop_op_q   <= OP_NOP;
                        wb_valid_q <= 1'b1;
                        state      <= S_DONE;
                    end else if (watchdog == WD_LAST) begin
                        wb_data_q  <= '0;
                        wb_exc_q   <= EXC_TIMEOUT;
                        cop_op_q   <= OP_NOP;
                        wb_valid_q <= 1'b1;
                        state      <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (bus.wb_ready) begin
                        wb_valid_q <= 1'b0;
                        state      <= S_IDLE;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    cop_op_q <= OP_NOP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matcop_issue_ctrl.sv
// tb/tb_matcop_issue_ctrl.sv - self-checking bench for matcop_issue_ctrl
module tb_matcop_issue_ctrl;
    localparam int OPC_W   = 6;
    localparam int GPR_W   = 32;
    localparam int RA_W    = 5;
    localparam int TIMEOUT = 32;
    localparam int NEVER   = 1000;
    localparam logic [OPC_W-1:0] OP_NOP  = '0;
    localparam logic [OPC_W-1:0] OP_MUL  = 6'h18;
    localparam logic [OPC_W-1:0] OP_MULI = 6'h19;
    localparam logic [OPC_W-1:0] OP_DVM  = 6'h1a;
    localparam logic [OPC_W-1:0] OP_DVMI = 6'h1b;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    matcop_issue_ctrl_if #(.OPC_W(OPC_W), .GPR_W(GPR_W), .RA_W(RA_W)) bus ();

    matcop_issue_ctrl #(
        .OPC_W(OPC_W), .GPR_W(GPR_W), .RA_W(RA_W), .OP_NOP(OP_NOP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Snapshot of every output, compared against reset values in one go.
    logic [1+2+GPR_W+RA_W+OPC_W+GPR_W+GPR_W+1+1-1:0] outs;
    logic [1+2+GPR_W+RA_W+OPC_W+GPR_W+GPR_W+1+1-1:0] reset_outs;
    assign outs = {bus.wb_valid, bus.wb_exc, bus.wb_data, bus.wb_rd, bus.cop_op,
                   bus.cop_rs, bus.cop_rt, bus.issue_ready, bus.stall};
    assign reset_outs = {1'b0, 2'd0, 32'd0, 5'd0, OP_NOP, 32'd0, 32'd0, 1'b1, 1'b0};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.issue_valid      = 1'b0;
        bus.issue_op         = '0;
        bus.issue_rs         = '0;
        bus.issue_rt         = '0;
        bus.issue_rd         = '0;
        bus.flush            = 1'b0;
        bus.cop_rd_value     = '0;
        bus.cop_result_valid = 1'b0;
        bus.cop_error        = 1'b0;
        bus.wb_ready         = 1'b0;
    endtask

    // Reference: the coprocessor answers in BUSY cycle resp_k (0 = first cycle after issue).
    // Any answer before the watchdog expires wins; otherwise a timeout after TIMEOUT cycles.
    function automatic void model(input int resp_k, input bit err, input logic [31:0] val,
                                  output int lat, output logic [1:0] exc, output logic [31:0] data);
        if (resp_k < TIMEOUT) begin
            lat  = resp_k + 1;
            exc  = err ? 2'd1 : 2'd0;
            data = err ? 32'd0 : val;
        end else begin
            lat  = TIMEOUT;
            exc  = 2'd2;
            data = 32'd0;
        end
    endfunction

    // Full transaction from issue to writeback handshake; leaves the controller in IDLE.
    task automatic run_txn(input string tag, input logic [5:0] op, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [4:0] rd, input int resp_k,
                           input bit vflag, input bit err, input logic [31:0] val,
                           input int wb_delay, input bit early_issue);
        int          exp_lat;
        logic [1:0]  exp_exc;
        logic [31:0] exp_data;
        int          lat;
        bit          seen;
        model(resp_k, err, val, exp_lat, exp_exc, exp_data);

        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_rs    = rs;
        bus.issue_rt    = rt;
        bus.issue_rd    = rd;
        #1;
        n_checks++;
        if ({bus.issue_ready, bus.stall} !== 2'b11) begin
            n_fail++;
            $display("FAIL %s issue_hs: ready/stall=%b expected 11", tag, {bus.issue_ready, bus.stall});
        end
        cyc();
        bus.issue_valid = 1'b0;
        bus.issue_op    = 6'($urandom);
        bus.issue_rs    = $urandom;
        bus.issue_rt    = $urandom;
        bus.issue_rd    = 5'($urandom);
        n_checks++;
        if ({bus.cop_op, bus.cop_rs, bus.cop_rt, bus.wb_rd, bus.wb_valid} !== {op, rs, rt, rd, 1'b0}) begin
            n_fail++;
            $display("FAIL %s latch: op=%h rs=%h rt=%h rd=%h wbv=%b expected %h %h %h %h 0",
                     tag, bus.cop_op, bus.cop_rs, bus.cop_rt, bus.wb_rd, bus.wb_valid, op, rs, rt, rd);
        end

        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < TIMEOUT + 8 && !seen; k++) begin
            if (k == resp_k) begin
                bus.cop_result_valid = vflag;
                bus.cop_error        = err;
                bus.cop_rd_value     = val;
            end else begin
                bus.cop_result_valid = 1'b0;
                bus.cop_error        = 1'b0;
                bus.cop_rd_value     = $urandom;
            end
            #1;
            n_checks++;
            if ({bus.stall, bus.cop_op, bus.cop_rs, bus.cop_rt} !== {1'b1, op, rs, rt}) begin
                n_fail++;
                $display("FAIL %s busy_hold k=%0d: stall=%b op=%h rs=%h rt=%h expected 1 %h %h %h",
                         tag, k, bus.stall, bus.cop_op, bus.cop_rs, bus.cop_rt, op, rs, rt);
            end
            cyc();
            lat++;
            if (bus.wb_valid === 1'b1) seen = 1'b1;
        end
        bus.cop_result_valid = 1'b0;
        bus.cop_error        = 1'b0;

        n_checks++;
        if (!seen || lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: seen=%0d after %0d cycles expected %0d", tag, seen, lat, exp_lat);
        end
        n_checks++;
        if ({bus.wb_exc, bus.wb_data, bus.wb_rd, bus.cop_op, bus.issue_ready} !==
            {exp_exc, exp_data, rd, OP_NOP, 1'b0}) begin
            n_fail++;
            $display("FAIL %s result: exc=%0d data=%h rd=%h op=%h ready=%b expected %0d %h %h %h 0",
                     tag, bus.wb_exc, bus.wb_data, bus.wb_rd, bus.cop_op, bus.issue_ready,
                     exp_exc, exp_data, rd, OP_NOP);
        end

        for (int d = 0; d < wb_delay; d++) begin
            #1;
            n_checks++;
            if ({bus.stall, bus.wb_valid, bus.wb_exc, bus.wb_data, bus.wb_rd} !==
                {1'b1, 1'b1, exp_exc, exp_data, rd}) begin
                n_fail++;
                $display("FAIL %s wb_hold d=%0d: stall=%b v=%b exc=%0d data=%h expected 1 1 %0d %h",
                         tag, d, bus.stall, bus.wb_valid, bus.wb_exc, bus.wb_data, exp_exc, exp_data);
            end
            cyc();
        end

        bus.wb_ready = 1'b1;
        if (early_issue) begin
            bus.issue_valid = 1'b1;
            bus.issue_op    = OP_MUL;
        end
        #1;
        n_checks++;
        if ({bus.stall, bus.issue_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s handshake: stall/ready=%b expected 00", tag, {bus.stall, bus.issue_ready});
        end
        cyc();
        bus.wb_ready = 1'b0;
        n_checks++;
        if ({bus.wb_valid, bus.issue_ready, bus.cop_op} !== {1'b0, 1'b1, OP_NOP}) begin
            n_fail++;
            $display("FAIL %s post_wb: v=%b ready=%b op=%h expected 0 1 %h",
                     tag, bus.wb_valid, bus.issue_ready, bus.cop_op, OP_NOP);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        n_checks++;
        if (outs !== reset_outs) begin
            n_fail++;
            $display("FAIL reset_state: outputs=%h expected %h", outs, reset_outs);
        end
    endtask

    task automatic test_mul();
        run_txn("mul_7x6", OP_MUL, 32'd7, 32'd6, 5'd9, 4, 1'b1, 1'b0, 32'd42, 0, 1'b0);
        run_txn("muli", OP_MULI, 32'hffff_fffe, 32'd3, 5'd31, 0, 1'b1, 1'b0, 32'hffff_fffa, 1, 1'b0);
    endtask

    task automatic test_div_backpressure();
        run_txn("dvm_100_7", OP_DVM, 32'd100, 32'd7, 5'd3, 19, 1'b1, 1'b0, {16'd2, 16'd14}, 3, 1'b0);
    endtask

    task automatic test_div_zero();
        run_txn("dvm_zero", OP_DVM, 32'd100, 32'd0, 5'd4, 19, 1'b1, 1'b1, 32'hdead_beef, 0, 1'b0);
        run_txn("dvmi_err_only", OP_DVMI, 32'd5, 32'd0, 5'd6, 7, 1'b0, 1'b1, 32'h1234_5678, 2, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn("timeout", OP_DVM, 32'd9, 32'd2, 5'd7, NEVER, 1'b1, 1'b0, 32'd0, 1, 1'b0);
        run_txn("last_cycle_result", OP_MUL, 32'd3, 32'd5, 5'd8, TIMEOUT - 1, 1'b1, 1'b0, 32'd15, 0, 1'b0);
        run_txn("last_cycle_error", OP_DVMI, 32'd3, 32'd0, 5'd10, TIMEOUT - 1, 1'b1, 1'b1, 32'd1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_first", OP_MUL, 32'd11, 32'd13, 5'd1, 2, 1'b1, 1'b0, 32'd143, 0, 1'b1);
        run_txn("b2b_second", OP_DVM, 32'd50, 32'd5, 5'd2, 5, 1'b1, 1'b0, 32'd10, 0, 1'b0);
    endtask

    task automatic test_flush();
        idle_inputs();
        bus.issue_valid = 1'b1;
        bus.issue_op    = OP_DVM;
        bus.issue_rs    = 32'd77;
        bus.issue_rt    = 32'd3;
        bus.issue_rd    = 5'd12;
        cyc();
        bus.issue_valid = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        n_checks++;
        if ({bus.issue_ready, bus.cop_op, bus.wb_valid, bus.wb_exc} !== {1'b1, OP_NOP, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL flush_busy: ready=%b op=%h v=%b exc=%0d expected 1 %h 0 0",
                     bus.issue_ready, bus.cop_op, bus.wb_valid, bus.wb_exc, OP_NOP);
        end
        bus.cop_result_valid = 1'b1;
        bus.cop_rd_value     = 32'd25;
        cyc();
        bus.cop_result_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({bus.wb_valid, bus.issue_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL flush_late_result i=%0d: v/ready=%b expected 01", i, {bus.wb_valid, bus.issue_ready});
            end
            cyc();
        end

        bus.issue_valid = 1'b1;
        bus.issue_op    = OP_MULI;
        bus.flush       = 1'b1;
        cyc();
        bus.issue_valid = 1'b0;
        bus.flush       = 1'b0;
        n_checks++;
        if ({bus.cop_op, bus.issue_ready} !== {OP_NOP, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_idle: op=%h ready=%b expected %h 1", bus.cop_op, bus.issue_ready, OP_NOP);
        end

        bus.issue_valid = 1'b1;
        bus.issue_op    = OP_MUL;
        cyc();
        bus.issue_valid      = 1'b0;
        bus.cop_result_valid = 1'b1;
        bus.cop_rd_value     = 32'd99;
        cyc();
        bus.cop_result_valid = 1'b0;
        bus.flush            = 1'b1;
        cyc();
        bus.flush = 1'b0;
        n_checks++;
        if ({bus.wb_valid, bus.wb_exc, bus.issue_ready} !== {1'b0, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_done: v=%b exc=%0d ready=%b expected 0 0 1", bus.wb_valid, bus.wb_exc, bus.issue_ready);
        end
    endtask

    task automatic test_rst_mid();
        idle_inputs();
        bus.issue_valid = 1'b1;
        bus.issue_op    = OP_DVMI;
        bus.issue_rs    = 32'hcafe_0001;
        bus.issue_rt    = 32'd9;
        bus.issue_rd    = 5'd17;
        cyc();
        bus.issue_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_checks++;
        if (outs !== reset_outs) begin
            n_fail++;
            $display("FAIL rst_busy: outputs=%h expected %h", outs, reset_outs);
        end
        bus.issue_valid = 1'b1;
        bus.issue_op    = OP_MUL;
        bus.issue_rs    = 32'd4;
        bus.issue_rt    = 32'd8;
        bus.issue_rd    = 5'd21;
        cyc();
        bus.issue_valid = 1'b0;
        n_checks++;
        if ({bus.cop_op, bus.cop_rs, bus.wb_rd} !== {OP_MUL, 32'd4, 5'd21}) begin
            n_fail++;
            $display("FAIL issue_after_rst: op=%h rs=%h rd=%h expected %h 4 15", bus.cop_op, bus.cop_rs, bus.wb_rd, OP_MUL);
        end
        bus.cop_result_valid = 1'b1;
        bus.cop_rd_value     = 32'd32;
        cyc();
        bus.cop_result_valid = 1'b0;
        n_checks++;
        if ({bus.wb_valid, bus.wb_data} !== {1'b1, 32'd32}) begin
            n_fail++;
            $display("FAIL pre_rst_done: v=%b data=%h expected 1 20", bus.wb_valid, bus.wb_data);
        end
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_checks++;
        if (outs !== reset_outs) begin
            n_fail++;
            $display("FAIL rst_done: outputs=%h expected %h", outs, reset_outs);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[4];
        int         resp_k;
        bit         err;
        bit         vflag;
        ops = '{OP_MUL, OP_MULI, OP_DVM, OP_DVMI};
        idle_inputs();
        for (int t = 0; t < 40; t++) begin
            resp_k = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, TIMEOUT - 1));
            err    = ($urandom_range(0, 3) == 0);
            vflag  = err ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn($sformatf("rand%0d", t), ops[$urandom_range(0, 3)], $urandom, $urandom,
                    5'($urandom), resp_k, vflag, err, $urandom, int'($urandom_range(0, 3)),
                    (t != 39) && ($urandom_range(0, 1) == 1));
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div_backpressure();
        test_div_zero();
        test_timeout();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/matcop_issue_ctrl.md
Name: matcop_issue_ctrl

Overview:
- Issue/writeback controller directly upstream of the multiply/divide-mod coprocessor.
- Accepts one decoded MUL/MULI/DVM/DVMI instruction from the execute stage and holds opcode and operands stable at the coprocessor for the whole operation.
- Stalls the pipeline while the coprocessor works, then captures the 32-bit result or error and presents it to writeback through a valid/ready handshake.
- Adds flush handling and a watchdog timeout, which the coprocessor lacks.

Parameters:
OPC_W, 6, opcode width (matches OPC_BIT)
GPR_W, 32, register width (matches GPR_BIT)
RA_W, 5, destination register address width
OP_NOP, 0, opcode driven to coprocessor when idle (coprocessor decodes it as not working)
TIMEOUT, 32, max BUSY cycles without cop_result_valid before a timeout exception; must exceed the divide period (20)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
issue_valid  in  1  execute stage presents a coprocessor instruction
issue_ready  out  1  controller can accept; high only in IDLE
issue_op  in  OPC_W  opcode (MUL/MULI/DVM/DVMI)
issue_rs  in  GPR_W  operand A (dividend / multiplicand)
issue_rt  in  GPR_W  operand B (divisor / multiplier; immediate already extended)
issue_rd  in  RA_W  destination register address
flush  in  1  pipeline flush; aborts in-flight operation
stall  out  1  freeze upstream pipeline stages
cop_op  out  OPC_W  registered opcode to coprocessor
cop_rs  out  GPR_W  registered operand A
cop_rt  out  GPR_W  registered operand B
cop_rd_value  in  GPR_W  coprocessor result
cop_result_valid  in  1  coprocessor result valid this cycle
cop_error  in  1  coprocessor error (divide by zero)
wb_valid  out  1  result/exception ready for writeback
wb_ready  in  1  writeback accepts
wb_rd  out  RA_W  destination address
wb_data  out  GPR_W  captured result (0 on exception)
wb_exc  out  2  0 none, 1 divide-by-zero, 2 timeout

Behaviour:
- States: IDLE, BUSY, DONE. On reset: state=IDLE, cop_op=OP_NOP, cop_rs/cop_rt/wb_data=0, wb_rd=0, wb_exc=0, wb_valid=0, stall=0, watchdog=0.
- Outputs are registered except issue_ready (=state==IDLE) and stall.
- stall = (issue_valid & state==IDLE) | state==BUSY | (state==DONE & !wb_ready).
- IDLE: issue_valid & !flush -> latch op/rs/rt/rd into cop_op/cop_rs/cop_rt/wb_rd; watchdog<=0; go BUSY.
- Operands stay constant at the coprocessor for the whole BUSY period.
- BUSY: watchdog increments every cycle.
  - cop_result_valid -> wb_data<=cop_rd_value, wb_exc<=cop_error?1:0 (wb_data<=0 if error), cop_op<=OP_NOP, wb_valid<=1, go DONE.
  - cop_error asserted without cop_result_valid -> same capture with wb_exc=1, wb_data=0.
- Timeout: watchdog==TIMEOUT-1 with no valid/error -> wb_exc=2, wb_data=0, cop_op<=OP_NOP, wb_valid<=1, go DONE.
- Simultaneous events: cop_result_valid and timeout in the same cycle -> the result wins.
- DONE: hold wb_* stable while wb_valid & !wb_ready. On wb_ready -> wb_valid<=0, go IDLE.
- No back-to-back issue: the next instruction is accepted no earlier than the cycle after the writeback handshake.
- flush: highest priority after rst in every state -> cop_op<=OP_NOP, wb_valid<=0, wb_exc<=0, state IDLE. A flushed result is never written back. flush in IDLE blocks acceptance that cycle.
- Latency: MUL result visible on wb_valid 1 cycle after cop_result_valid. Total = coprocessor period + 2 cycles from issue.
- wb_data is the full GPR_W coprocessor output: product, or quotient/remainder packing as produced. No width conversion.

Test Plan:
- MUL 7*6: issue, cop_result_valid after 4 cycles with 42 -> wb_valid next cycle, wb_data=42, wb_exc=0, wb_rd=issue_rd, stall high from issue until handshake.
- DVM 100/7 with wb_ready held low 3 cycles after wb_valid -> wb_data stable at coprocessor value, stall high until wb_ready, then IDLE with issue_ready=1.
- DVM by 0: cop_error + cop_result_valid -> wb_exc=1, wb_data=0.
- Coprocessor never responds -> wb_valid exactly TIMEOUT cycles after entering BUSY, wb_exc=2, cop_op returns to OP_NOP.
- flush on 5th BUSY cycle -> next cycle IDLE, cop_op=OP_NOP, no wb_valid even if cop_result_valid arrives later.
- rst asserted in BUSY and in DONE -> all outputs at reset values next cycle. Issue accepted the cycle after rst deasserts.
